// File: rtl/legv8_alu_pkg.sv
// Shared types and constants for the LEGv8 ALU arbiter slice.
// Holds the widths, FSM encoding, NZCV layout and the request/response payloads.
package legv8_alu_pkg;

  localparam int unsigned DW     = 64;
  localparam int unsigned OPW    = 11;
  localparam int unsigned NZCV_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [OPW-1:0] ALU_ADD  = 11'b00000100000;
  localparam logic [OPW-1:0] ALU_ADDU = 11'b00000100001;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic           setflags;
    logic           id;
  } alu_req_t;

  typedef struct packed {
    logic [DW-1:0]     data;
    logic [NZCV_W-1:0] flags;
  } alu_rsp_t;

  // N comes from the result MSB; Z/C/V are taken straight from the ALU.
  function automatic logic [NZCV_W-1:0] pack_nzcv(input logic [DW-1:0] res,
                                                  input logic          z,
                                                  input logic          c,
                                                  input logic          v);
    logic [NZCV_W-1:0] f;
    f         = '0;
    f[FLAG_N] = res[DW-1];
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/legv8_rr_arb2.sv
// Two-way round-robin grant; a tie goes to the requester not granted last.
// Grant outputs are combinational and only asserted while en_i is high.
module legv8_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_c_o,
  output logic       gnt_id_c_o
);

  logic last_q;
  logic last_d;

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    gnt_c_o    = 2'b00;
    gnt_id_c_o = 1'b0;
    last_d     = last_q;
    case (req_i)
      2'b01:   gnt_id_c_o = 1'b0;
      2'b10:   gnt_id_c_o = 1'b1;
      2'b11:   gnt_id_c_o = ~last_q;
      default: gnt_id_c_o = 1'b0;
    endcase
    if (en_i && (req_i != 2'b00)) begin
      gnt_c_o[gnt_id_c_o] = 1'b1;
      last_d              = gnt_id_c_o;
    end
  end

endmodule

// File: rtl/legv8_alu_arbiter.sv
// Shares one external combinational LEGv8 ALU between two requesters.
// Round-robin accept, registered operand launch, registered result with valid/ready, NZCV register.
module legv8_alu_arbiter
  import legv8_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OPW-1:0]    req0_op,
  input  logic [OPW-1:0]    req1_op,
  input  logic [DW-1:0]     req0_a,
  input  logic [DW-1:0]     req1_a,
  input  logic [DW-1:0]     req0_b,
  input  logic [DW-1:0]     req1_b,
  input  logic [1:0]        req_setflags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DW-1:0]     rsp_data,
  output logic [NZCV_W-1:0] rsp_flags,
  output logic [NZCV_W-1:0] nzcv,
  output logic [OPW-1:0]    alu_op,
  output logic [DW-1:0]     alu_in0,
  output logic [DW-1:0]     alu_in1,
  input  logic [DW-1:0]     alu_out,
  input  logic              alu_zero,
  input  logic              alu_carryout,
  input  logic              alu_overflow
);

  state_e            state_q, state_d;
  alu_req_t          req_q, req_d;
  alu_rsp_t          rsp_q, rsp_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [NZCV_W-1:0] nzcv_q, nzcv_d;

  logic [1:0] gnt_c;
  logic       gnt_id_c;
  logic       arb_en_c;

  // Grants are only offered in IDLE and never while reset is held.
  assign arb_en_c = (state_q == ST_IDLE) && !rst;

  legv8_rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_valid),
    .en_i       (arb_en_c),
    .gnt_c_o    (gnt_c),
    .gnt_id_c_o (gnt_id_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      nzcv_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      nzcv_q      <= nzcv_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    nzcv_d      = nzcv_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_c != 2'b00) begin
          req_d.op       = gnt_id_c ? req1_op : req0_op;
          req_d.a        = gnt_id_c ? req1_a  : req0_a;
          req_d.b        = gnt_id_c ? req1_b  : req0_b;
          req_d.setflags = req_setflags[gnt_id_c];
          req_d.id       = gnt_id_c;
          state_d        = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_d.data  = alu_out;
        rsp_d.flags = pack_nzcv(alu_out, alu_zero, alu_carryout, alu_overflow);
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (req_q.setflags) begin
            nzcv_d = rsp_q.flags;
          end
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  assign req_ready = gnt_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = req_q.id;
  assign rsp_data  = rsp_q.data;
  assign rsp_flags = rsp_q.flags;
  assign nzcv      = nzcv_q;
  assign alu_op    = req_q.op;
  assign alu_in0   = req_q.a;
  assign alu_in1   = req_q.b;

endmodule
